mult_hilo_unit: RTL and testbench

Control and result stage wrapped around the sequential 16×16 multiplier. It accepts MULT requests from decode, latches the operands, and drives the multiplier's start/operand inputs. It captures the 32-bit product into HI/LO and serves MFHI/MFLO reads, stalling the pipeline while a multiply is in flight. A watchdog flags a multiplier that never completes.

---
 rtl/mult_pkg.sv | 30 +++
 rtl/mult_timeout_ctr.sv | 47 ++++
 rtl/mult_hilo_unit.sv | 155 +++++++++++++++
 tb/tb_mult_hilo_unit.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mult_pkg
//  Purpose  : Shared definitions for the MULT/HI/LO result stage: FSM state
//             encoding, default operand width and watchdog limit, and the
//             bit positions of the HI and LO halves within the product.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package mult_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2
  } state_t;

  localparam int unsigned c_DEF_WIDTH   = 16;
  localparam int unsigned c_DEF_TIMEOUT = 64;

  // LO occupies the bottom WIDTH bits of the product.
  localparam int unsigned c_LO_BASE = 0;

  // HI starts directly above LO, so its base is the operand width.
  function automatic int unsigned hi_base(input int unsigned width);
    return width;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mult_timeout_ctr.sv
`default_nettype none
// ============================================================================
//  Module   : mult_timeout_ctr
//  Purpose  : Watchdog for an in-flight multiply. Counts enabled cycles and
//             reports expiry on the cycle that would make the count reach
//             TIMEOUT, so the owning FSM can abort on that same edge.
//  Ports    : clk       - clock
//             rst       - synchronous active-high reset
//             i_clear   - restart the count (dominates i_enable)
//             i_enable  - count this cycle
//             o_expired - this enabled cycle is the TIMEOUT-th one
//  Revision : 1.0 - initial release
// ============================================================================
module mult_timeout_ctr
  import mult_pkg::*;
#(
  parameter int unsigned TIMEOUT = c_DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int unsigned c_CW = $clog2(TIMEOUT + 1);

  logic [c_CW-1:0] r_count;
  logic            w_at_limit;

  // The count holds the number of enabled cycles already completed; when it
  // equals TIMEOUT-1 the current enabled cycle is the last one allowed.
  assign w_at_limit = (r_count == c_CW'(TIMEOUT - 1));
  assign o_expired  = i_enable & w_at_limit;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && !w_at_limit) begin
      r_count <= r_count + c_CW'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/mult_hilo_unit.sv
`default_nettype none
// ============================================================================
//  Module   : mult_hilo_unit
//  Purpose  : Control/result stage around a sequential WIDTH x WIDTH
//             multiplier. Accepts MULT, launches the multiplier, captures the
//             unsigned 2*WIDTH product into HI/LO, serves MFHI/MFLO reads and
//             stalls the pipeline while a multiply is in flight. A watchdog
//             aborts a multiply that never completes and raises a sticky flag.
//  Ports    : Clk, Rst                 - clock, synchronous active-high reset
//             Mult_Req, Op_A, Op_B     - MULT request and operands
//             Mfhi_Req, Mflo_Req       - HI/LO read requests (HI wins)
//             Mul_St                   - multiplier start
//             Mul_Multiplicando/_dor   - latched operands to multiplier
//             Mul_Done, Mul_Idle       - multiplier status
//             Mul_Produto              - multiplier result
//             Stall, Busy              - pipeline stall, FSM not idle
//             Rd_Data, Rd_Valid        - read result and its qualifier
//             Timeout_Err              - sticky watchdog error
//  Revision : 1.0 - initial release
// ============================================================================
module mult_hilo_unit
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH   = c_DEF_WIDTH,
  parameter int unsigned TIMEOUT = c_DEF_TIMEOUT
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               Mult_Req,
  input  logic [WIDTH-1:0]   Op_A,
  input  logic [WIDTH-1:0]   Op_B,
  input  logic               Mfhi_Req,
  input  logic               Mflo_Req,
  output logic               Mul_St,
  output logic [WIDTH-1:0]   Mul_Multiplicando,
  output logic [WIDTH-1:0]   Mul_Multiplicador,
  input  logic               Mul_Done,
  input  logic               Mul_Idle,
  input  logic [2*WIDTH-1:0] Mul_Produto,
  output logic               Stall,
  output logic               Busy,
  output logic [WIDTH-1:0]   Rd_Data,
  output logic               Rd_Valid,
  output logic               Timeout_Err
);

  localparam int unsigned c_HI_LSB = hi_base(WIDTH);
  localparam int unsigned c_LO_LSB = c_LO_BASE;

  state_t           r_state;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_op_a;
  logic [WIDTH-1:0] r_op_b;
  logic             r_mul_st;
  logic [WIDTH-1:0] r_rd_data;
  logic             r_rd_valid;
  logic             r_timeout_err;

  logic w_idle;
  logic w_busy;
  logic w_accept;
  logic w_expired;

  assign w_idle   = (r_state == S_IDLE);
  assign w_busy   = ~w_idle;
  assign w_accept = w_idle & Mult_Req & Mul_Idle;

  // Any request while busy must wait; a MULT in IDLE also waits while the
  // multiplier is still finishing something of its own.
  assign Stall = (w_busy & (Mult_Req | Mfhi_Req | Mflo_Req))
               | (w_idle & Mult_Req & ~Mul_Idle);

  assign Busy              = w_busy;
  assign Mul_St            = r_mul_st;
  assign Mul_Multiplicando = r_op_a;
  assign Mul_Multiplicador = r_op_b;
  assign Rd_Data           = r_rd_data;
  assign Rd_Valid          = r_rd_valid;
  assign Timeout_Err       = r_timeout_err;

  mult_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_ctr (
    .clk       (Clk),
    .rst       (Rst),
    .i_clear   (w_accept),
    .i_enable  (w_busy),
    .o_expired (w_expired)
  );

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state       <= S_IDLE;
      r_hi          <= '0;
      r_lo          <= '0;
      r_op_a        <= '0;
      r_op_b        <= '0;
      r_mul_st      <= 1'b0;
      r_rd_data     <= '0;
      r_rd_valid    <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_rd_valid <= 1'b0;

      unique case (r_state)
        S_IDLE: begin
          // Reads see HI/LO as they are now, even if a MULT is accepted on
          // the same edge.
          if (Mfhi_Req || Mflo_Req) begin
            r_rd_data  <= Mfhi_Req ? r_hi : r_lo;
            r_rd_valid <= 1'b1;
          end
          if (w_accept) begin
            r_op_a   <= Op_A;
            r_op_b   <= Op_B;
            r_mul_st <= 1'b1;
            r_state  <= S_LAUNCH;
          end
        end

        S_LAUNCH: begin
          if (w_expired) begin
            r_timeout_err <= 1'b1;
            r_mul_st      <= 1'b0;
            r_state       <= S_IDLE;
          end else if (!Mul_Idle) begin
            // Multiplier has left idle, so it has taken the start.
            r_mul_st <= 1'b0;
            r_state  <= S_WAIT;
          end
        end

        S_WAIT: begin
          // A completion on the final allowed cycle still counts.
          if (Mul_Done) begin
            r_hi    <= Mul_Produto[c_HI_LSB +: WIDTH];
            r_lo    <= Mul_Produto[c_LO_LSB +: WIDTH];
            r_state <= S_IDLE;
          end else if (w_expired) begin
            r_timeout_err <= 1'b1;
            r_state       <= S_IDLE;
          end
        end

        default: begin
          r_mul_st <= 1'b0;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mult_hilo_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mult_hilo_unit
//  Purpose  : Directed self-checking bench for mult_hilo_unit. The bench
//             plays the multiplier itself, driving Mul_Idle/Mul_Done and a
//             hand-computed Mul_Produto.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mult_hilo_unit;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        Mult_Req;
  logic [15:0] Op_A;
  logic [15:0] Op_B;
  logic        Mfhi_Req;
  logic        Mflo_Req;
  logic        Mul_St;
  logic [15:0] Mul_Multiplicando;
  logic [15:0] Mul_Multiplicador;
  logic        Mul_Done;
  logic        Mul_Idle;
  logic [31:0] Mul_Produto;
  logic        Stall;
  logic        Busy;
  logic [15:0] Rd_Data;
  logic        Rd_Valid;
  logic        Timeout_Err;

  int n_total = 0;
  int n_bad   = 0;

  always #5 Clk = ~Clk;

  mult_hilo_unit #(
    .WIDTH   (16),
    .TIMEOUT (64)
  ) dut (
    .Clk               (Clk),
    .Rst               (Rst),
    .Mult_Req          (Mult_Req),
    .Op_A              (Op_A),
    .Op_B              (Op_B),
    .Mfhi_Req          (Mfhi_Req),
    .Mflo_Req          (Mflo_Req),
    .Mul_St            (Mul_St),
    .Mul_Multiplicando (Mul_Multiplicando),
    .Mul_Multiplicador (Mul_Multiplicador),
    .Mul_Done          (Mul_Done),
    .Mul_Idle          (Mul_Idle),
    .Mul_Produto       (Mul_Produto),
    .Stall             (Stall),
    .Busy              (Busy),
    .Rd_Data           (Rd_Data),
    .Rd_Valid          (Rd_Valid),
    .Timeout_Err       (Timeout_Err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_total++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Advance one edge and settle away from it.
  task automatic tick();
    @(posedge Clk);
    #2;
  endtask

  // Read HI (hi=1) or LO (hi=0) in IDLE and check the returned value.
  task automatic rd(input logic hi, input logic [15:0] exp_v, input string tag);
    Mfhi_Req = hi;
    Mflo_Req = ~hi;
    tick();
    Mfhi_Req = 1'b0;
    Mflo_Req = 1'b0;
    chk({tag, "_valid"}, 32'(Rd_Valid), 32'd1);
    chk({tag, "_data"},  32'(Rd_Data),  32'(exp_v));
  endtask

  // Accept a MULT, let the multiplier take the start, then finish with prod.
  task automatic run_mult(input logic [15:0] a, input logic [15:0] b,
                          input logic [31:0] prod, input string tag);
    Mult_Req = 1'b1; Op_A = a; Op_B = b;
    tick();
    Mult_Req = 1'b0;
    chk({tag, "_st"},   32'(Mul_St),            32'd1);
    chk({tag, "_opa"},  32'(Mul_Multiplicando), 32'(a));
    chk({tag, "_opb"},  32'(Mul_Multiplicador), 32'(b));
    Mul_Idle = 1'b0;
    tick();
    chk({tag, "_st_low"}, 32'(Mul_St), 32'd0);
    Mul_Done = 1'b1; Mul_Produto = prod;
    tick();
    Mul_Done = 1'b0; Mul_Idle = 1'b1; Mul_Produto = 32'hDEAD_BEEF;
    chk({tag, "_busy_after"}, 32'(Busy), 32'd0);
  endtask

  initial begin
    Rst = 1'b1; Mult_Req = 1'b0; Op_A = '0; Op_B = '0;
    Mfhi_Req = 1'b0; Mflo_Req = 1'b0;
    Mul_Done = 1'b0; Mul_Idle = 1'b1; Mul_Produto = '0;
    tick(); tick();

    // ---- reset state ----
    chk("rst_busy",  32'(Busy),              32'd0);
    chk("rst_st",    32'(Mul_St),            32'd0);
    chk("rst_valid", 32'(Rd_Valid),          32'd0);
    chk("rst_data",  32'(Rd_Data),           32'd0);
    chk("rst_err",   32'(Timeout_Err),       32'd0);
    chk("rst_opa",   32'(Mul_Multiplicando), 32'd0);
    chk("rst_stall", 32'(Stall),             32'd0);
    Rst = 1'b0;
    tick();

    // ---- 3 x 5: start held while multiplier still idle ----
    Mult_Req = 1'b1; Op_A = 16'd3; Op_B = 16'd5;
    #1 chk("m35_stall_idle", 32'(Stall), 32'd0);
    tick();
    Mult_Req = 1'b0; Op_A = '0; Op_B = '0;
    chk("m35_st",   32'(Mul_St),            32'd1);
    chk("m35_busy", 32'(Busy),              32'd1);
    chk("m35_opa",  32'(Mul_Multiplicando), 32'd3);
    chk("m35_opb",  32'(Mul_Multiplicador), 32'd5);
    Mul_Done = 1'b1; Mul_Produto = 32'h0000_0099;  // done during LAUNCH: ignored
    tick();
    Mul_Done = 1'b0;
    chk("m35_st_hold", 32'(Mul_St), 32'd1);
    Mul_Idle = 1'b0;
    tick();
    chk("m35_st_drop", 32'(Mul_St), 32'd0);
    chk("m35_wait_busy", 32'(Busy), 32'd1);
    Mul_Done = 1'b1; Mul_Produto = 32'd15;
    tick();
    Mul_Done = 1'b0; Mul_Idle = 1'b1;
    chk("m35_busy_done", 32'(Busy), 32'd0);
    rd(1'b0, 16'd15, "m35_lo");
    rd(1'b1, 16'd0,  "m35_hi");
    tick();
    chk("m35_valid_pulse", 32'(Rd_Valid), 32'd0);

    // ---- 0xFFFF x 0xFFFF = 0xFFFE0001 ----
    run_mult(16'hFFFF, 16'hFFFF, 32'hFFFE_0001, "mff");
    rd(1'b1, 16'hFFFE, "mff_hi");
    rd(1'b0, 16'h0001, "mff_lo");

    // ---- read + MULT same cycle, then MFLO stalled across 7 x 7 ----
    Mult_Req = 1'b1; Op_A = 16'd7; Op_B = 16'd7; Mflo_Req = 1'b1;
    tick();
    Mult_Req = 1'b0;
    chk("m77_pre_valid", 32'(Rd_Valid), 32'd1);
    chk("m77_pre_data",  32'(Rd_Data),  32'h0001);
    chk("m77_busy",      32'(Busy),     32'd1);
    #1 chk("m77_stall_launch", 32'(Stall), 32'd1);
    Mul_Idle = 1'b0;
    tick();
    chk("m77_stall_w1", 32'(Stall),    32'd1);
    chk("m77_novalid",  32'(Rd_Valid), 32'd0);
    tick();
    chk("m77_stall_w2", 32'(Stall),    32'd1);
    Mul_Done = 1'b1; Mul_Produto = 32'd49;
    tick();
    Mul_Done = 1'b0; Mul_Idle = 1'b1;
    chk("m77_stall_free", 32'(Stall),    32'd0);
    chk("m77_capture_nv", 32'(Rd_Valid), 32'd0);
    tick();
    Mflo_Req = 1'b0;
    chk("m77_rd_valid", 32'(Rd_Valid), 32'd1);
    chk("m77_rd_data",  32'(Rd_Data),  32'd49);

    // ---- MULT refused while multiplier busy ----
    Mul_Idle = 1'b0; Mult_Req = 1'b1; Op_A = 16'd9; Op_B = 16'd11;
    #1 chk("ref_stall", 32'(Stall), 32'd1);
    tick();
    chk("ref_busy", 32'(Busy),              32'd0);
    chk("ref_st",   32'(Mul_St),            32'd0);
    chk("ref_opa",  32'(Mul_Multiplicando), 32'd7);
    tick();
    chk("ref_opb",  32'(Mul_Multiplicador), 32'd7);
    Mul_Idle = 1'b1;
    #1 chk("ref_stall_rel", 32'(Stall), 32'd0);
    tick();                                   // acceptance edge N
    Mult_Req = 1'b0;
    chk("ref_acc_opa", 32'(Mul_Multiplicando), 32'd9);
    chk("ref_acc_st",  32'(Mul_St),            32'd1);

    // ---- never-completing multiply: abort at N+64 ----
    Mul_Idle = 1'b0;
    for (int i = 0; i < 63; i++) tick();      // now just after N+63
    chk("to_err_early",  32'(Timeout_Err), 32'd0);
    chk("to_busy_early", 32'(Busy),        32'd1);
    tick();                                   // N+64
    chk("to_err",  32'(Timeout_Err), 32'd1);
    chk("to_busy", 32'(Busy),        32'd0);
    Mul_Idle = 1'b1;
    rd(1'b0, 16'd49, "to_old_lo");
    Mfhi_Req = 1'b1; Mflo_Req = 1'b1;         // both: HI wins
    tick();
    Mfhi_Req = 1'b0; Mflo_Req = 1'b0;
    chk("to_both_hi", 32'(Rd_Data), 32'd0);
    chk("to_sticky",  32'(Timeout_Err), 32'd1);

    // ---- reset during WAIT, late Done must not update HI/LO ----
    Mult_Req = 1'b1; Op_A = 16'd2; Op_B = 16'd3;
    tick();
    Mult_Req = 1'b0; Mul_Idle = 1'b0;
    tick();
    Rst = 1'b1;
    tick();
    Rst = 1'b0; Mul_Done = 1'b1; Mul_Produto = 32'h1234_5678;
    tick();
    Mul_Done = 1'b0; Mul_Idle = 1'b1;
    chk("rw_busy",  32'(Busy),              32'd0);
    chk("rw_st",    32'(Mul_St),            32'd0);
    chk("rw_err",   32'(Timeout_Err),       32'd0);
    chk("rw_opa",   32'(Mul_Multiplicando), 32'd0);
    chk("rw_valid", 32'(Rd_Valid),          32'd0);
    chk("rw_data",  32'(Rd_Data),           32'd0);
    rd(1'b0, 16'd0, "rw_lo");
    rd(1'b1, 16'd0, "rw_hi");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
